// File: rtl/spu_fetch_unit_if.sv
// Local store read port between the SPU fetch unit (master) and the local store arbiter (slave).
// A read transfers when ls_rd_en && ls_rd_grant on a rising edge; ls_rd_data holds the pair the following cycle; en/addr stay stable until granted.
interface spu_fetch_unit_if #(
  parameter int LS_ADDR_W = 18
);
  logic                 ls_rd_en;
  logic [LS_ADDR_W-1:0] ls_rd_addr;
  logic                 ls_rd_grant;
  logic [63:0]          ls_rd_data;

  modport master (
    output ls_rd_en,
    output ls_rd_addr,
    input  ls_rd_grant,
    input  ls_rd_data
  );

  modport slave (
    input  ls_rd_en,
    input  ls_rd_addr,
    output ls_rd_grant,
    output ls_rd_data
  );
endinterface

// File: rtl/spu_fetch_unit.sv
// SPU instruction fetch: prefetches aligned even/odd pairs from local store into a small FIFO.
// Optional performance counters are enabled by defining SPU_FETCH_PERF_EN.
module spu_fetch_unit #(
  parameter int                    LS_ADDR_W = 18,
  parameter int                    BUF_DEPTH = 4,
  parameter logic [LS_ADDR_W-1:0]  RESET_PC  = '0,
  parameter logic [31:0]           NOP_INSTR = 32'h4020_0000
) (
  input  logic                 clk,
  input  logic                 reset,
  spu_fetch_unit_if.master     ls,
  input  logic                 stallEven,
  input  logic                 stallOdd,
  input  logic                 branch_taken,
  input  logic [LS_ADDR_W-1:0] branch_target,
  output logic [31:0]          instruction1_IF,
  output logic [31:0]          instruction2_IF,
  output logic [LS_ADDR_W-1:0] pc_IF,
  output logic                 fetch_valid
`ifdef SPU_FETCH_PERF_EN
  ,
  output logic [31:0]          perf_bubble_cnt,
  output logic [31:0]          perf_redirect_cnt
`endif
);

  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int CNT_W = $clog2(BUF_DEPTH + 1);

  logic [LS_ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [PTR_W-1:0]     head_q, head_d, tail_q, tail_d;
  logic                 inflight_q, inflight_d;
  logic                 pad_q, pad_d;

  logic [63:0]          pair_mem [BUF_DEPTH];
  logic [LS_ADDR_W-1:0] pc_mem   [BUF_DEPTH];

  logic                 pop, issue, ret;
  logic [CNT_W:0]       occ;
  logic                 unused_tgt_bits;

  assign unused_tgt_bits = ^branch_target[1:0];

  always_comb begin
    fetch_valid = (count_q != '0);
    pop         = fetch_valid && !stallEven && !stallOdd;
    // Occupancy counts the in-flight pair so a returning read always has a free slot.
    occ         = {1'b0, count_q} + (CNT_W+1)'(inflight_q) - (CNT_W+1)'(pop);
    issue       = reset && !branch_taken && (occ < (CNT_W+1)'(BUF_DEPTH));
    ret         = inflight_q && !branch_taken;

    ls.ls_rd_en   = issue;
    ls.ls_rd_addr = issue ? fetch_pc_q : '0;

    instruction1_IF = fetch_valid ? pair_mem[head_q][63:32] : '0;
    instruction2_IF = fetch_valid ? pair_mem[head_q][31:0]  : '0;
    pc_IF           = fetch_valid ? pc_mem[head_q]          : '0;
  end

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    count_d    = count_q;
    head_d     = head_q;
    tail_d     = tail_q;
    inflight_d = 1'b0;
    pad_d      = pad_q;
    if (branch_taken) begin
      count_d    = '0;
      head_d     = '0;
      tail_d     = '0;
      fetch_pc_d = {branch_target[LS_ADDR_W-1:3], 3'b000};
      pad_d      = branch_target[2];
    end else begin
      if (issue && ls.ls_rd_grant) begin
        inflight_d = 1'b1;
        fetch_pc_d = fetch_pc_q + LS_ADDR_W'(8);
      end
      if (ret) begin
        tail_d = tail_q + PTR_W'(1);
        pad_d  = 1'b0;
      end
      if (pop) head_d = head_q + PTR_W'(1);
      count_d = count_q + CNT_W'(ret) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc_q <= RESET_PC;
      count_q    <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      inflight_q <= 1'b0;
      pad_q      <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      count_q    <= count_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      inflight_q <= inflight_d;
      pad_q      <= pad_d;
    end
  end

  // While a read is in flight fetch_pc_q has already advanced one pair past it.
  always_ff @(posedge clk) begin
    if (ret) begin
      pair_mem[tail_q] <= {(pad_q ? NOP_INSTR : ls.ls_rd_data[63:32]), ls.ls_rd_data[31:0]};
      pc_mem[tail_q]   <= fetch_pc_q - LS_ADDR_W'(8);
    end
  end

`ifdef SPU_FETCH_PERF_EN
  logic [31:0] bubble_q, redirect_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bubble_q   <= '0;
      redirect_q <= '0;
    end else begin
      if (!fetch_valid && !stallEven && !stallOdd && (bubble_q != '1))
        bubble_q <= bubble_q + 32'd1;
      if (branch_taken && (redirect_q != '1))
        redirect_q <= redirect_q + 32'd1;
    end
  end

  assign perf_bubble_cnt   = bubble_q;
  assign perf_redirect_cnt = redirect_q;
`endif

endmodule

// File: doc/spu_fetch_unit.md
# spu_fetch_unit

Instruction fetch stage of the dual-issue SPU pipeline. It reads aligned instruction pairs (even/odd slot) from local store, queues them in a small prefetch buffer, and presents one pair per cycle on instruction1_IF/instruction2_IF to the IF/ID pipeline register. It honours the even/odd stall signals and redirects on taken branches, handling odd-word branch targets by NOP-padding the even slot.

## Interface
- LS_ADDR_W, 18: local store byte-address width (256 KB).
- BUF_DEPTH, 4: prefetch buffer depth in instruction pairs. Power of two, ≥2.
- RESET_PC, 0: byte address fetched after reset. Low 3 bits must be zero.
- NOP_INSTR, 32'h4020_0000: encoding placed in the even slot for odd-word branch targets.

- clk  in  1  pipeline clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- ls_rd_en  out  1  local store read request.
- ls_rd_addr  out  LS_ADDR_W  request byte address; low 3 bits always 0.
- ls_rd_grant  in  1  arbiter accepts the request this cycle.
- ls_rd_data  in  64  returned pair, one cycle after grant; [63:32] = word at addr, [31:0] = word at addr+4.
- stallEven, stallOdd  in  1  downstream hold requests.
- branch_taken  in  1  redirect strobe.
- branch_target  in  LS_ADDR_W  redirect byte address; bit 2 selects odd word, bits [1:0] ignored.
- instruction1_IF, instruction2_IF  out  32  even/odd slot of head pair; 0 when buffer empty.
- pc_IF  out  LS_ADDR_W  byte address of instruction1_IF; 0 when empty.
- fetch_valid  out  1  head pair valid.

## Operation
- State: fetch_pc, buffer (BUF_DEPTH pairs + per-entry pc), count, inflight flag, pad_pending flag.
- Reset (reset=0): fetch_pc=RESET_PC, count=0, inflight=0, pad_pending=0. Outputs: ls_rd_en=0, ls_rd_addr=0, instruction*_IF=0, pc_IF=0, fetch_valid=0.
- Consume: pop = fetch_valid && !stallEven && !stallOdd. Either stall holds the head pair unchanged.
- Issue: ls_rd_en=1 when !branch_taken and (count + inflight − pop) < BUF_DEPTH. On ls_rd_en && ls_rd_grant: inflight=1 next cycle, fetch_pc += 8 (modulo 2^LS_ADDR_W; wraps to 0).
- Ungranted request: ls_rd_en and ls_rd_addr held stable until granted.
- Return: in the cycle with inflight=1, ls_rd_data is written at the tail. If pad_pending, the stored even slot is NOP_INSTR and pad_pending clears.
- Redirect (branch_taken=1): buffer cleared (count=0), inflight data discarded, fetch_pc={branch_target[LS_ADDR_W-1:3],3'b000}, pad_pending=branch_target[2]. No request issued in the redirect cycle. Redirect overrides a simultaneous pop, return, and grant.
- Full: no request issued; simultaneous pop+return keeps count unchanged.
- Empty: outputs all-zero (bubble); pop cannot occur.

## Timing
- Request granted in cycle N → data captured at end of N+1 → pair visible on outputs in N+2.
- First pair after reset release: visible no earlier than cycle 2 (grant held high).
- branch_taken in cycle R: outputs 0 in R+1, request to target in R+1, target pair visible in R+3 (2-bubble penalty with grant high).
- Steady state with grant high and no stalls: one pair per cycle, no bubbles, for any BUF_DEPTH ≥2.
- Reset assertion mid-operation clears all state immediately, independent of clk.

## Configuration
- SPU_FETCH_PERF_EN defined: adds outputs perf_bubble_cnt[31:0] (cycles with fetch_valid=0 and both stalls low) and perf_redirect_cnt[31:0] (branch_taken cycles). Both are saturating, cleared by reset.
- SPU_FETCH_PERF_EN undefined: these ports and counters are absent; all other behaviour is identical.

## Test plan
- Reset release, grant=1, memory word i = i, no stalls → pairs (0,1),(2,3),(4,5) from cycle 2, pc_IF 0,8,16.
- stallOdd=1 for 3 cycles mid-stream → head pair and pc_IF held; 4 pairs buffered, ls_rd_en drops; no pair lost or duplicated on release.
- branch_taken with target 0x104 while a read is in flight → stale data dropped; outputs 0 for 2 cycles, then instruction1_IF=NOP_INSTR, instruction2_IF=word@0x104, pc_IF=0x100.
- grant=0 for 5 cycles → ls_rd_addr held; buffer drains to empty, outputs 0; resumes correctly.
- RESET_PC=0x3FFF8 → pairs from 0x3FFF8, then 0x00000 (wrap).
- reset pulsed low between clock edges mid-stream → all outputs 0 immediately; fetch restarts at RESET_PC.
